// File: rtl/ft245_fifo_responder.sv
// FT245-style FIFO responder: host-side RX/TX FIFOs exposed to a controller through RD/WR strobes.
// Define FT245_RESP_SYNC_EN to add 2-stage synchronizers on RD, WR and USBX_I (adds 2 CLKs of strobe latency).
module ft245_fifo_responder #(
    parameter int RX_DEPTH  = 16,
    parameter int TX_DEPTH  = 64,
    parameter int PRECHARGE = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rd,
    input  logic       i_wr,
    input  logic [7:0] i_usbx,
    output logic [7:0] o_usbx,
    output logic       o_usbx_oe,
    output logic       o_rxf,
    output logic       o_txe,
    input  logic [7:0] i_host_wdata,
    input  logic       i_host_wvalid,
    output logic       o_host_wready,
    output logic [7:0] o_host_rdata,
    output logic       o_host_rvalid,
    input  logic       i_host_rready,
    output logic [8:0] o_rx_level,
    output logic [8:0] o_tx_level,
    output logic       o_underrun,
    output logic       o_overrun
);

    localparam int         RX_AW    = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int         TX_AW    = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam logic [8:0] RX_FULL  = 9'(RX_DEPTH);
    localparam logic [8:0] TX_FULL  = 9'(TX_DEPTH);
    localparam logic [3:0] PRE_LOAD = 4'(PRECHARGE);

    logic       w_rd;
    logic       w_wr;
    logic [7:0] w_usbx;

`ifdef FT245_RESP_SYNC_EN
    // RD chain resets low so a strobe held low through reset never looks like a fresh edge.
    logic [1:0] r_rd_sync;
    logic [1:0] r_wr_sync;
    logic [7:0] r_usbx_sync1;
    logic [7:0] r_usbx_sync2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_sync    <= 2'b00;
            r_wr_sync    <= 2'b00;
            r_usbx_sync1 <= 8'h00;
            r_usbx_sync2 <= 8'h00;
        end else begin
            r_rd_sync    <= {r_rd_sync[0], i_rd};
            r_wr_sync    <= {r_wr_sync[0], i_wr};
            r_usbx_sync1 <= i_usbx;
            r_usbx_sync2 <= r_usbx_sync1;
        end
    end

    assign w_rd   = r_rd_sync[1];
    assign w_wr   = r_wr_sync[1];
    assign w_usbx = r_usbx_sync2;
`else
    assign w_rd   = i_rd;
    assign w_wr   = i_wr;
    assign w_usbx = i_usbx;
`endif

    logic r_rd_q;
    logic r_wr_q;
    logic r_rd_seen_hi;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_q       <= 1'b1;
            r_wr_q       <= 1'b0;
            r_rd_seen_hi <= 1'b0;
        end else begin
            r_rd_q <= w_rd;
            r_wr_q <= w_wr;
            if (w_rd) r_rd_seen_hi <= 1'b1;
        end
    end

    logic w_rd_fall;
    logic w_rd_rise;
    logic w_wr_fall;

    assign w_rd_fall = r_rd_q & ~w_rd & r_rd_seen_hi;
    assign w_rd_rise = ~r_rd_q & w_rd;
    assign w_wr_fall = r_wr_q & ~w_wr;

    // RX FIFO: host pushes, controller pops on the RD rise that closes a serviced read.
    logic [7:0]       r_rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] r_rx_wptr;
    logic [RX_AW-1:0] r_rx_rptr;
    logic [8:0]       r_rx_level;
    logic             r_rd_pend;
    logic             w_rx_push;
    logic             w_rx_pop;

    assign o_host_wready = ~i_rst & (r_rx_level != RX_FULL);
    assign w_rx_push     = i_host_wvalid & o_host_wready;
    assign w_rx_pop      = w_rd_rise & r_rd_pend;

    always_ff @(posedge i_clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= i_host_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_level <= 9'd0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            if (w_rx_push && !w_rx_pop)      r_rx_level <= r_rx_level + 9'd1;
            else if (!w_rx_push && w_rx_pop) r_rx_level <= r_rx_level - 9'd1;
        end
    end

    logic [7:0] r_usbx_o;
    logic       r_oe;
    logic       r_rd_busy;
    logic [3:0] r_rx_pre;
    logic       r_underrun;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_usbx_o   <= 8'h00;
            r_oe       <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_rd_busy  <= 1'b0;
            r_rx_pre   <= 4'd0;
            r_underrun <= 1'b0;
        end else if (w_rd_fall) begin
            r_oe      <= 1'b1;
            r_rd_busy <= 1'b1;
            if (r_rx_level != 9'd0) begin
                r_usbx_o  <= r_rx_mem[r_rx_rptr];
                r_rd_pend <= 1'b1;
            end else begin
                r_usbx_o   <= 8'h00;
                r_underrun <= 1'b1;
            end
        end else if (w_rd_rise) begin
            r_oe      <= 1'b0;
            r_usbx_o  <= 8'h00;
            r_rd_pend <= 1'b0;
            if (r_rd_busy) begin
                r_rd_busy <= 1'b0;
                r_rx_pre  <= PRE_LOAD;
            end
        end else if (r_rx_pre != 4'd0) begin
            r_rx_pre <= r_rx_pre - 4'd1;
        end
    end

    // TX FIFO: controller pushes on WR fall, host pops first-word fall-through.
    logic [7:0]       r_tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] r_tx_wptr;
    logic [TX_AW-1:0] r_tx_rptr;
    logic [8:0]       r_tx_level;
    logic [3:0]       r_tx_pre;
    logic             r_overrun;
    logic             w_tx_full;
    logic             w_tx_push;
    logic             w_tx_pop;

    assign w_tx_full     = (r_tx_level == TX_FULL);
    assign w_tx_push     = w_wr_fall & ~w_tx_full;
    assign o_host_rvalid = ~i_rst & (r_tx_level != 9'd0);
    assign w_tx_pop      = o_host_rvalid & i_host_rready;

    always_ff @(posedge i_clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= w_usbx;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_level <= 9'd0;
            r_tx_pre   <= 4'd0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
            if (w_tx_push && !w_tx_pop)      r_tx_level <= r_tx_level + 9'd1;
            else if (!w_tx_push && w_tx_pop) r_tx_level <= r_tx_level - 9'd1;
            if (w_wr_fall) begin
                r_tx_pre <= PRE_LOAD;
                if (w_tx_full) r_overrun <= 1'b1;
            end else if (r_tx_pre != 4'd0) begin
                r_tx_pre <= r_tx_pre - 4'd1;
            end
        end
    end

    assign o_usbx       = r_usbx_o;
    assign o_usbx_oe    = r_oe;
    assign o_rxf        = i_rst | r_rd_busy | (r_rx_pre != 4'd0) | (r_rx_level == 9'd0);
    assign o_txe        = i_rst | (r_tx_pre != 4'd0) | w_tx_full;
    assign o_host_rdata = r_tx_mem[r_tx_rptr];
    assign o_rx_level   = r_rx_level;
    assign o_tx_level   = r_tx_level;
    assign o_underrun   = r_underrun;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_ft245_fifo_responder.sv
// Randomized bench for ft245_fifo_responder against a queue-based transaction model.
module tb_ft245_fifo_responder;

    localparam int RXD = 16;
    localparam int TXD = 64;
    localparam int PRE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rd = 1'b1;
    logic       wr = 1'b1;
    logic [7:0] usbx_i = 8'h00;
    logic [7:0] usbx_o;
    logic       usbx_oe, rxf, txe;
    logic [7:0] wdata = 8'h00;
    logic       wvalid = 1'b0;
    logic       wready;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rready = 1'b0;
    logic [8:0] rx_level, tx_level;
    logic       underrun, overrun;

    ft245_fifo_responder #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .PRECHARGE(PRE)) dut (
        .i_clk(clk), .i_rst(rst), .i_rd(rd), .i_wr(wr), .i_usbx(usbx_i),
        .o_usbx(usbx_o), .o_usbx_oe(usbx_oe), .o_rxf(rxf), .o_txe(txe),
        .i_host_wdata(wdata), .i_host_wvalid(wvalid), .o_host_wready(wready),
        .o_host_rdata(rdata), .o_host_rvalid(rvalid), .i_host_rready(rready),
        .o_rx_level(rx_level), .o_tx_level(tx_level),
        .o_underrun(underrun), .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    bit         m_under = 1'b0;
    bit         m_over = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        wvalid = 1'b0;
        rready = 1'b0;
        tick();
        chk("rst_oe_drop", 32'(usbx_oe), 32'(0));
        for (int i = 1; i < n; i++) tick();
        chk("rst_rxf", 32'(rxf), 32'(1));
        chk("rst_txe", 32'(txe), 32'(1));
        chk("rst_usbx", 32'(usbx_o), 32'(0));
        chk("rst_wready", 32'(wready), 32'(0));
        chk("rst_rvalid", 32'(rvalid), 32'(0));
        chk("rst_levels", 32'({rx_level, tx_level}), 32'(0));
        chk("rst_flags", 32'({underrun, overrun}), 32'(0));
        rx_q.delete();
        tx_q.delete();
        m_under = 1'b0;
        m_over = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_txe", 32'(txe), 32'(0));
        chk("post_rst_wready", 32'(wready), 32'(1));
    endtask

    task automatic host_push(input logic [7:0] b);
        bit acc;
        wvalid = 1'b1;
        wdata = b;
        acc = (rx_q.size() < RXD);
        #1;
        chk("wready", 32'(wready), 32'(acc));
        tick();
        wvalid = 1'b0;
        if (acc) rx_q.push_back(b);
        chk("rx_level_push", 32'(rx_level), 32'(rx_q.size()));
    endtask

    task automatic host_pop();
        bit had;
        had = (tx_q.size() != 0);
        chk("rvalid", 32'(rvalid), 32'(had));
        if (had) chk("rdata", 32'(rdata), 32'(tx_q[0]));
        rready = 1'b1;
        tick();
        rready = 1'b0;
        if (had) void'(tx_q.pop_front());
        chk("tx_level_pop", 32'(tx_level), 32'(tx_q.size()));
    endtask

    task automatic rd_cycle(input int low_n, input bit push_rise, input logic [7:0] pb);
        logic [7:0] exp;
        bit had, acc;
        acc = 1'b0;
        chk("rxf_idle", 32'(rxf), 32'(rx_q.size() == 0));
        had = (rx_q.size() != 0);
        exp = had ? rx_q[0] : 8'h00;
        rd = 1'b0;
        tick();
        if (!had) m_under = 1'b1;
        chk("rd_oe", 32'(usbx_oe), 32'(1));
        chk("rd_data", 32'(usbx_o), 32'(exp));
        chk("rd_rxf_busy", 32'(rxf), 32'(1));
        chk("underrun", 32'(underrun), 32'(m_under));
        chk("rx_level_hold", 32'(rx_level), 32'(rx_q.size()));
        for (int i = 0; i < low_n; i++) begin
            tick();
            chk("rd_oe_hold", 32'(usbx_oe), 32'(1));
            chk("rd_data_hold", 32'(usbx_o), 32'(exp));
        end
        rd = 1'b1;
        if (push_rise) begin
            wvalid = 1'b1;
            wdata = pb;
            acc = (rx_q.size() < RXD);
            #1;
            chk("wready_rise", 32'(wready), 32'(acc));
        end
        tick();
        wvalid = 1'b0;
        if (had) void'(rx_q.pop_front());
        if (acc) rx_q.push_back(pb);
        chk("rd_oe_off", 32'(usbx_oe), 32'(0));
        chk("rx_level_rd", 32'(rx_level), 32'(rx_q.size()));
        for (int i = 0; i < PRE; i++) begin
            chk("rxf_precharge", 32'(rxf), 32'(1));
            tick();
        end
        chk("rxf_after", 32'(rxf), 32'(rx_q.size() == 0));
    endtask

    task automatic wr_cycle(input logic [7:0] b, input bit full_check);
        usbx_i = b;
        wr = 1'b0;
        tick();
        if (tx_q.size() < TXD) tx_q.push_back(b);
        else m_over = 1'b1;
        chk("wr_txe", 32'(txe), 32'(1));
        chk("tx_level_wr", 32'(tx_level), 32'(tx_q.size()));
        chk("overrun", 32'(overrun), 32'(m_over));
        wr = 1'b1;
        if (full_check) begin
            for (int i = 0; i < PRE; i++) begin
                chk("txe_precharge", 32'(txe), 32'(1));
                tick();
            end
            chk("txe_after", 32'(txe), 32'(tx_q.size() == TXD));
        end else begin
            tick();
        end
    endtask

    task automatic tx_both(input logic [7:0] b);
        bit full;
        full = (tx_q.size() == TXD);
        chk("both_rdata", 32'(rdata), 32'(tx_q[0]));
        usbx_i = b;
        wr = 1'b0;
        rready = 1'b1;
        tick();
        rready = 1'b0;
        wr = 1'b1;
        void'(tx_q.pop_front());
        if (!full) tx_q.push_back(b);
        else m_over = 1'b1;
        chk("both_level", 32'(tx_level), 32'(tx_q.size()));
        for (int i = 0; i < PRE; i++) tick();
        chk("both_txe", 32'(txe), 32'(tx_q.size() == TXD));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(3);
        tick();
        tick();

        // single byte host -> controller, RD held low 8 CLKs
        host_push(8'h07);
        rd_cycle(7, 1'b0, 8'h00);

        // read with RX empty
        rd_cycle(2, 1'b0, 8'h00);

        // fill TX from the controller, then one overflow byte
        for (int i = 0; i < 64; i++) wr_cycle(8'(i), 1'b0);
        wr_cycle(8'hAA, 1'b1);
        for (int i = 0; i < 64; i++) host_pop();
        chk("tx_drained", 32'(rvalid), 32'(0));

        // host streams 20 bytes into a 16-deep RX FIFO
        for (int i = 0; i < 20; i++) begin
            bit acc;
            wvalid = 1'b1;
            wdata = 8'(i);
            acc = (rx_q.size() < RXD);
            #1;
            chk("stream_wready", 32'(wready), 32'(acc));
            tick();
            if (acc) rx_q.push_back(8'(i));
        end
        wvalid = 1'b0;
        chk("stream_level", 32'(rx_level), 32'(16));
        chk("stream_full_wready", 32'(wready), 32'(0));
        for (int i = 0; i < 4; i++) rd_cycle(1, 1'b0, 8'h00);
        while (rx_q.size() != 0) rd_cycle(0, 1'b0, 8'h00);

        // reset in the middle of a read, RD kept low through and after it
        host_push(8'h55);
        rd = 1'b0;
        tick();
        chk("midread_oe", 32'(usbx_oe), 32'(1));
        do_reset(3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stuck_rd_no_oe", 32'(usbx_oe), 32'(0));
        end
        host_push(8'h66);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stuck_rd_no_oe2", 32'(usbx_oe), 32'(0));
        end
        rd = 1'b1;
        tick();
        chk("rd_release_no_oe", 32'(usbx_oe), 32'(0));
        rd_cycle(1, 1'b0, 8'h00);

        // random traffic on both FIFOs
        for (int n = 0; n < 300; n++) begin
            int op;
            op = int'($urandom_range(0, 7));
            case (op)
                0, 1: host_push(8'($urandom));
                2, 3: rd_cycle(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom));
                4, 5: wr_cycle(8'($urandom), 1'b1);
                6:    host_pop();
                default: begin
                    if (tx_q.size() != 0) tx_both(8'($urandom));
                    else host_pop();
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ft245_fifo_responder.md
FT245_FIFO_RESPONDER -- requirements
Module: ft245_fifo_responder

Interface
REQ-001 Parameter RX_DEPTH, default 16, host-to-controller command FIFO depth; SHALL be a power of two, 2..256.
REQ-002 Parameter TX_DEPTH, default 64, controller-to-host data FIFO depth; SHALL be a power of two, 2..256.
REQ-003 Parameter PRECHARGE, default 2, CLK cycles RXF/TXE are held high after each transfer; SHALL be 1..15.
REQ-004 CLK  in  1  single clock; all logic on its rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 RD  in  1  FT245 read strobe from controller, active low.
REQ-007 WR  in  1  FT245 write strobe from controller; data latched on its falling edge.
REQ-008 USBX_I  in  8  controller-driven bus value.
REQ-009 USBX_O  out  8  responder-driven bus value.
REQ-010 USBX_OE  out  1  high while the responder drives the bus.
REQ-011 RXF  out  1  low = RX FIFO byte available to controller.
REQ-012 TXE  out  1  low = TX FIFO can accept a byte.
REQ-013 HOST_WDATA  in  8, HOST_WVALID  in  1, HOST_WREADY  out  1  host push port into the RX FIFO.
REQ-014 HOST_RDATA  out  8, HOST_RVALID  out  1, HOST_RREADY  in  1  host pop port from the TX FIFO, first-word fall-through.
REQ-015 RX_LEVEL  out  9, TX_LEVEL  out  9  current FIFO occupancy.
REQ-016 UNDERRUN  out  1, OVERRUN  out  1  sticky error flags.

Function
REQ-017 Edge detection SHALL compare RD and WR against their values registered on the previous CLK.
REQ-018 On an RD falling edge with the RX FIFO non-empty, the responder SHALL drive the FIFO head on USBX_O with USBX_OE=1 starting on the next CLK.
REQ-019 USBX_OE SHALL remain 1 while RD is low and SHALL fall on the CLK after the RD rising edge.
REQ-020 The RX FIFO SHALL pop exactly once per RD rising edge that follows a serviced falling edge.
REQ-021 On an RD falling edge with the RX FIFO empty, the responder SHALL drive 0x00, set UNDERRUN, and SHALL NOT pop.
REQ-022 RXF SHALL go high on the CLK after an RD falling edge, SHALL stay high for PRECHARGE CLKs after the RD rising edge, and SHALL then equal (RX_LEVEL==0).
REQ-023 On a WR falling edge with the TX FIFO not full, USBX_I SHALL be pushed into the TX FIFO.
REQ-024 On a WR falling edge with the TX FIFO full, the byte SHALL be dropped and OVERRUN set.
REQ-025 TXE SHALL go high for PRECHARGE CLKs after each WR falling edge and SHALL then equal (TX_LEVEL==TX_DEPTH).
REQ-026 HOST_WREADY SHALL be !(RX_LEVEL==RX_DEPTH); a push SHALL occur when HOST_WVALID and HOST_WREADY are both 1.
REQ-027 A byte pushed on cycle k SHALL be visible to RXF and RD no earlier than cycle k+1.
REQ-028 HOST_RVALID SHALL be (TX_LEVEL!=0) with HOST_RDATA equal to the TX head; a pop SHALL occur when HOST_RVALID and HOST_RREADY are both 1.
REQ-029 Simultaneous push and pop on the same FIFO SHALL leave LEVEL unchanged and preserve order.
REQ-030 FIFO pointers SHALL wrap modulo DEPTH; LEVEL SHALL never exceed DEPTH or go negative.
REQ-031 UNDERRUN and OVERRUN SHALL clear only on RST.

Reset
REQ-032 While RST=1: both FIFOs empty, RX_LEVEL=TX_LEVEL=0, RXF=1, TXE=1, USBX_OE=0, USBX_O=0x00, HOST_WREADY=0, HOST_RVALID=0, UNDERRUN=OVERRUN=0, precharge counters 0.
REQ-033 The first CLK after RST falls, TXE SHALL be 0 and HOST_WREADY SHALL be 1.
REQ-034 The edge-history registers SHALL reset to 1 for RD and 0 for WR, so RD held low through reset SHALL NOT be serviced until RD has been seen high.
REQ-035 Asserting RST mid-read SHALL drop USBX_OE on the next CLK and discard the pending pop.

Configuration
REQ-036 With macro FT245_RESP_SYNC_EN defined, RD, WR and USBX_I SHALL pass through 2-stage synchronizers before edge detection; every strobe-relative latency SHALL increase by 2 CLKs.
REQ-037 Without FT245_RESP_SYNC_EN, RD, WR and USBX_I SHALL be used directly and no synchronizer flops SHALL exist.

Verification
REQ-038 Push 0x07 from host, then pull RD low 8 CLKs -> RXF falls; USBX_O=0x07 with OE=1 one CLK after RD falls; RX_LEVEL=0 after the RD rise; RXF stays high for 2 CLKs.
REQ-039 Pull RD low with the RX FIFO empty -> USBX_O=0x00; UNDERRUN=1; RX_LEVEL stays 0.
REQ-040 Issue 64 WR falling edges carrying 0x00..0x3F, then one more carrying 0xAA -> TXE=1; OVERRUN=1; the host reads exactly 0x00..0x3F in order.
REQ-041 Hold HOST_WVALID=1 for 20 CLKs with RX_DEPTH=16 -> HOST_WREADY falls when RX_LEVEL=16; 4 RD cycles then return bytes 0..3.
REQ-042 Hold RD low across a 3-CLK RST pulse -> no USBX_OE assertion until RD rises and falls again.
REQ-043 Rerun REQ-038 with FT245_RESP_SYNC_EN defined -> USBX_O is valid 3 CLKs after RD falls.
